// File: rtl/fetch_decode_if.sv
// rtl/fetch_decode_if.sv - fetch/decode bundle: byte memory port, redirect/halt control, instruction stream
interface fetch_decode_if #(
    parameter int ADDR_W = 16
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halt_program;
    logic              instr_valid;
    logic              instr_ready;
    logic [7:0]        OP_code;
    logic [7:0]        value;
    logic [ADDR_W-1:0] instr_pc;
    logic              illegal_op;
    logic              halted;

    modport master (
        output mem_rd, mem_addr, instr_valid, OP_code, value, instr_pc, illegal_op, halted,
        input  mem_rdata, redirect_valid, redirect_pc, halt_program, instr_ready
    );

    modport slave (
        input  mem_rd, mem_addr, instr_valid, OP_code, value, instr_pc, illegal_op, halted,
        output mem_rdata, redirect_valid, redirect_pc, halt_program, instr_ready
    );
endinterface

// File: rtl/fetch_decode.sv
// rtl/fetch_decode.sv - two-byte little-endian instruction fetch with redirect/halt handling
// Optional illegal-opcode trap enabled by defining ILLEGAL_OP_TRAP_EN.
module fetch_decode #(
    parameter int              ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int              PC_STEP     = 2,
    parameter logic [7:0]      LAST_OPCODE = 8'h0C
) (
    input  logic           clk,
    input  logic           rst,
    fetch_decode_if.master bus
);
`ifdef ILLEGAL_OP_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_LO, S_HI, S_CAP, S_OUT, S_HALT} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_pc;
    logic [7:0]        r_lo;
    logic [7:0]        r_op;
    logic [7:0]        r_val;
    logic [ADDR_W-1:0] r_ipc;
    logic              r_valid;
    logic              r_illegal;

    logic              w_xfer;
    logic              w_self_halt;
    logic              w_bad;
    logic              w_redirect;

    assign w_xfer      = r_valid & bus.instr_ready;
    // A transferred opcode 00 stops fetch even if a redirect arrives alongside it.
    assign w_self_halt = (r_state == S_OUT) & w_xfer & (r_op == 8'h00);
    assign w_bad       = TRAP_EN & (bus.mem_rdata > LAST_OPCODE);
    assign w_redirect  = bus.redirect_valid & (r_state != S_HALT) & ~bus.halt_program & ~w_self_halt;

    always_comb begin
        w_next       = r_state;
        bus.mem_rd   = 1'b0;
        bus.mem_addr = r_pc;
        case (r_state)
            S_LO: begin
                bus.mem_rd = ~rst;
                w_next     = S_HI;
            end
            S_HI: begin
                bus.mem_rd   = ~rst;
                bus.mem_addr = r_pc + ADDR_W'(1);
                w_next       = S_CAP;
            end
            S_CAP: w_next = S_OUT;
            S_OUT: begin
                if (w_xfer) w_next = w_self_halt ? S_HALT : S_LO;
            end
            default: w_next = S_HALT;
        endcase
        if (r_state != S_HALT) begin
            if (bus.halt_program)  w_next = S_HALT;
            else if (w_redirect)   w_next = S_LO;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_LO;
            r_pc      <= RESET_PC;
            r_lo      <= 8'h00;
            r_op      <= 8'h00;
            r_val     <= 8'h00;
            r_ipc     <= '0;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            r_valid <= (w_next == S_OUT);
            if (r_state == S_HI) r_lo <= bus.mem_rdata;
            if (r_state == S_CAP) begin
                r_op      <= w_bad ? 8'h00 : bus.mem_rdata;
                r_val     <= w_bad ? bus.mem_rdata : r_lo;
                r_ipc     <= r_pc;
                r_illegal <= (w_next == S_OUT) & w_bad;
            end else if (w_next == S_LO) begin
                r_illegal <= 1'b0;
            end
            if (w_redirect)
                r_pc <= bus.redirect_pc;
            else if (w_xfer && !bus.halt_program && !w_self_halt)
                r_pc <= r_pc + ADDR_W'(PC_STEP);
        end
    end

    assign bus.instr_valid = r_valid;
    assign bus.OP_code     = r_op;
    assign bus.value       = r_val;
    assign bus.instr_pc    = r_ipc;
    assign bus.illegal_op  = r_illegal;
    assign bus.halted      = (r_state == S_HALT);
endmodule

// File: tb/tb_fetch_decode.sv
// tb/tb_fetch_decode.sv - randomized bench for fetch_decode against a transaction-level fetch model
module tb_fetch_decode;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_decode_if #(.ADDR_W(16)) bus();
    fetch_decode dut (.clk(clk), .rst(rst), .bus(bus));

    logic [7:0] mem [0:65535];
    always @(posedge clk) if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];

    int n_cmp = 0;
    int n_mis = 0;
    int n_xfer = 0;

    // Model: the address of the next instruction to be delivered and whether fetch has stopped.
    logic [15:0] m_pc;
    logic        m_halt;
    logic        m_ill;
    logic        m_redir;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic exp_fields(output logic [7:0] op, output logic [7:0] val, output logic ill);
        logic [15:0] a1;
        a1  = m_pc + 16'd1;
        op  = mem[a1];
        val = mem[m_pc];
        ill = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
        if (mem[a1] > 8'h0C) begin
            op  = 8'h00;
            val = mem[a1];
            ill = 1'b1;
        end
`endif
    endtask

    task automatic step(input logic rv, input logic [15:0] rpc, input logic hp, input logic rdy);
        logic [7:0]  eop, evl;
        logic        eill, xfer, ok;
        logic [15:0] a1;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.halt_program   = hp;
        bus.instr_ready    = rdy;
        exp_fields(eop, evl, eill);
        a1 = m_pc + 16'd1;
        if (m_halt) begin
            check("halted", bus.halted, 1);
            check("valid_in_halt", bus.instr_valid, 0);
            check("mem_rd_in_halt", bus.mem_rd, 0);
            check("illegal_in_halt", bus.illegal_op, m_ill);
        end else begin
            check("not_halted", bus.halted, 0);
            if (m_redir) check("valid_after_redirect", bus.instr_valid, 0);
            if (bus.instr_valid) begin
                check("instr_pc", bus.instr_pc, m_pc);
                check("OP_code", bus.OP_code, eop);
                check("value", bus.value, evl);
                check("illegal_op", bus.illegal_op, eill);
                check("mem_rd_while_valid", bus.mem_rd, 0);
            end
            if (bus.mem_rd) begin
                ok = (bus.mem_addr == m_pc) || (bus.mem_addr == a1);
                check("mem_addr_range", ok, 1);
            end
        end
        xfer    = !m_halt && bus.instr_valid && rdy;
        m_redir = 1'b0;
        if (!m_halt) begin
            if (xfer) n_xfer++;
            if (hp) begin
                m_halt = 1'b1;
                m_ill  = bus.instr_valid && eill;
            end else if (xfer && eop == 8'h00) begin
                m_halt = 1'b1;
                m_ill  = eill;
            end else if (rv) begin
                m_pc    = rpc;
                m_redir = 1'b1;
            end else if (xfer) begin
                m_pc = m_pc + 16'd2;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 16'h0000;
        bus.halt_program   = 1'b0;
        bus.instr_ready    = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("mem_rd_in_reset", bus.mem_rd, 0);
        @(negedge clk);
        rst     = 1'b0;
        m_pc    = 16'h0000;
        m_halt  = 1'b0;
        m_ill   = 1'b0;
        m_redir = 1'b0;
        check("rst_valid", bus.instr_valid, 0);
        check("rst_halted", bus.halted, 0);
        check("rst_illegal", bus.illegal_op, 0);
        check("rst_op", bus.OP_code, 0);
        check("rst_value", bus.value, 0);
        check("rst_instr_pc", bus.instr_pc, 0);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 10; i++) begin
            if (bus.instr_valid) break;
            step(1'b0, 16'h0000, 1'b0, 1'b0);
        end
        check(tag, bus.instr_valid, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_valid;
        int nx0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom_range(1, 12));
        mem[0] = 8'h05; mem[1] = 8'h03;
        mem[16'h0040] = 8'h22; mem[16'h0041] = 8'h07;
        mem[16'hFFFE] = 8'h44; mem[16'hFFFF] = 8'h09;
        mem[16'h0100] = 8'h11; mem[16'h0101] = 8'h2A;
        @(negedge clk);
        do_reset();

        // Latency and first instruction
        first_valid = -1;
        for (int k = 0; k < 5; k++) begin
            if (bus.instr_valid && first_valid < 0) first_valid = k;
            if (k == 3) begin
                check("t1_op", bus.OP_code, 8'h03);
                check("t1_value", bus.value, 8'h05);
                check("t1_pc", bus.instr_pc, 0);
            end
            if (k == 4) begin
                check("t1_next_rd", bus.mem_rd, 1);
                check("t1_next_addr", bus.mem_addr, 16'h0002);
            end
            step(1'b0, 16'h0000, 1'b0, 1'b1);
        end
        check("t1_latency", first_valid, 3);

        // Back-pressure
        wait_valid("t2_valid");
        nx0 = n_xfer;
        for (int k = 0; k < 5; k++) step(1'b0, 16'h0000, 1'b0, 1'b0);
        check("t2_no_xfer", n_xfer, nx0);
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        check("t2_one_xfer", n_xfer, nx0 + 1);

        // Redirect during the high-byte read
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        step(1'b1, 16'h0040, 1'b0, 1'b1);
        check("t3_valid", bus.instr_valid, 0);
        check("t3_rd", bus.mem_rd, 1);
        check("t3_addr", bus.mem_addr, 16'h0040);
        wait_valid("t3_wait");
        check("t3_pc", bus.instr_pc, 16'h0040);
        check("t3_op", bus.OP_code, 8'h07);
        check("t3_value", bus.value, 8'h22);
        step(1'b0, 16'h0000, 1'b0, 1'b1);

        // Address wrap
        step(1'b1, 16'hFFFE, 1'b0, 1'b0);
        wait_valid("t5_wait");
        check("t5_pc", bus.instr_pc, 16'hFFFE);
        check("t5_op", bus.OP_code, 8'h09);
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        check("t5_rd", bus.mem_rd, 1);
        check("t5_addr", bus.mem_addr, 16'h0000);

        // Illegal opcode
        step(1'b1, 16'h0100, 1'b0, 1'b0);
        wait_valid("t6_wait");
`ifdef ILLEGAL_OP_TRAP_EN
        check("t6_op", bus.OP_code, 8'h00);
        check("t6_value", bus.value, 8'h2A);
        check("t6_illegal", bus.illegal_op, 1);
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        check("t6_halted", bus.halted, 1);
        check("t6_illegal_hold", bus.illegal_op, 1);
`else
        check("t6_op", bus.OP_code, 8'h2A);
        check("t6_value", bus.value, 8'h11);
        check("t6_illegal", bus.illegal_op, 0);
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        check("t6_halted", bus.halted, 0);
`endif

        // Self-halt on opcode 00 at 0x0006, later redirects ignored
        mem[0] = 8'h01; mem[1] = 8'h01; mem[2] = 8'h02; mem[3] = 8'h02;
        mem[4] = 8'h03; mem[5] = 8'h03; mem[6] = 8'h00; mem[7] = 8'h00;
        do_reset();
        n_xfer = 0;
        for (int k = 0; k < 24; k++) step(k >= 18, 16'h0040, 1'b0, 1'b1);
        check("t4_xfers", n_xfer, 4);
        check("t4_halted", bus.halted, 1);

        // Randomized traffic
        for (int r = 0; r < 4; r++) begin
            int halt_cyc;
            for (int a = 0; a < 65536; a++)
                mem[a] = ($urandom_range(0, 19) == 0) ? 8'($urandom) : 8'($urandom_range(1, 12));
            do_reset();
            halt_cyc = 0;
            for (int k = 0; k < 400; k++) begin
                logic        rv, hp, rdy;
                logic [15:0] rpc;
                rv  = ($urandom_range(0, 19) == 0);
                rpc = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFFC, 16'hFFFF)) : 16'($urandom);
                hp  = ($urandom_range(0, 199) == 0);
                rdy = ($urandom_range(0, 9) < 7);
                step(rv, rpc, hp, rdy);
                if (m_halt) halt_cyc++;
                if (halt_cyc > 6) begin
                    do_reset();
                    halt_cyc = 0;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
